// File: rtl/filter_pkg.sv
// Shared definitions for the img_filter scheduling controller:
// FSM state encoding, filter code constants and the filter-select width.
package filter_pkg;

    localparam int unsigned SEL_W   = 3;
    localparam int unsigned STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE      = 3'd0,
        ST_ARM       = 3'd1,
        ST_RUN       = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_RECOVER   = 3'd4
    } state_e;

    localparam logic [SEL_W-1:0] SEL_IMPULSE  = 3'd0;
    localparam logic [SEL_W-1:0] SEL_EDGE     = 3'd1;
    localparam logic [SEL_W-1:0] SEL_SOBEL    = 3'd2;
    localparam logic [SEL_W-1:0] SEL_RESERVED = 3'd5;

    // A frame is in flight (accelerator started or running).
    function automatic logic is_active(input state_e s);
        return (s == ST_RUN) || (s == ST_WAIT_DONE);
    endfunction

endpackage

// File: rtl/wdog_cnt.sv
// Per-frame watchdog counter.
// Ports: clk, RESET (sync, active-high), clear (zero the count),
//        enable (count this cycle), expire_c (count has reached
//        TIMEOUT_CYCLES-1 while enabled; combinational).
module wdog_cnt #(
    parameter int unsigned TIMEOUT_CYCLES = 4000000
) (
    input  logic clk,
    input  logic RESET,
    input  logic clear,
    input  logic enable,
    output logic expire_c
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear wins over enable.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (RESET) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_c = enable && (cnt_q == LIMIT);

endmodule

// File: rtl/filter_ctrl.sv
// Frame scheduler for the HLS img_filter core: arms on camera init,
// launches one accelerator run per frame boundary, latches the filter
// code per frame, counts completed frames and guards each frame with a
// watchdog.
// Ports: clk, RESET (sync, active-high); init_done, frame_start,
//        sel_req/sel_req_valid, ap_ready/ap_done/ap_idle, err_clr in;
//        ap_start, sel_V, capture_en, frame_cnt, sel_err, err_timeout,
//        state_o out (all registered).
module filter_ctrl
    import filter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 4000000,
    parameter int unsigned FCNT_W         = 16
) (
    input  logic              clk,
    input  logic              RESET,
    input  logic              init_done,
    input  logic              frame_start,
    input  logic [SEL_W-1:0]  sel_req,
    input  logic              sel_req_valid,
    input  logic              ap_ready,
    input  logic              ap_done,
    input  logic              ap_idle,
    input  logic              err_clr,
    output logic              ap_start,
    output logic [SEL_W-1:0]  sel_V,
    output logic              capture_en,
    output logic [FCNT_W-1:0] frame_cnt,
    output logic              sel_err,
    output logic              err_timeout,
    output logic [STATE_W-1:0] state_o
);

    state_e             state_q, state_d;
    logic [SEL_W-1:0]   sel_v_q, sel_v_d;
    logic [SEL_W-1:0]   pending_q, pending_d;
    logic [FCNT_W-1:0]  frame_cnt_q, frame_cnt_d;
    logic               sel_err_q, sel_err_d;
    logic               err_timeout_q, err_timeout_d;
    logic               ap_start_q, ap_start_d;
    logic               capture_en_q, capture_en_d;

    logic               wd_clear;
    logic               wd_enable;
    logic               wd_expire;
    logic               frame_done;

    assign wd_enable = is_active(state_q);

    wdog_cnt #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wdog (
        .clk     (clk),
        .RESET   (RESET),
        .clear   (wd_clear),
        .enable  (wd_enable),
        .expire_c(wd_expire)
    );

    // Next-state, filter-code bookkeeping and output decode.
    always_comb begin
        state_d       = state_q;
        sel_v_d       = sel_v_q;
        pending_d     = pending_q;
        frame_cnt_d   = frame_cnt_q;
        sel_err_d     = 1'b0;
        err_timeout_d = err_timeout_q;
        wd_clear      = 1'b0;
        frame_done    = 1'b0;

        // A request landing on the launch edge only reaches pending, so it
        // takes effect at the following frame.
        if (sel_req_valid) begin
            if (sel_req == SEL_RESERVED) begin
                sel_err_d = 1'b1;
            end else begin
                pending_d = sel_req;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (init_done) state_d = ST_ARM;
            end
            ST_ARM: begin
                if (!init_done) begin
                    state_d = ST_IDLE;
                end else if (frame_start) begin
                    state_d  = ST_RUN;
                    sel_v_d  = pending_q;
                    wd_clear = 1'b1;
                end
            end
            ST_RUN: begin
                if (wd_expire) begin
                    state_d = ST_RECOVER;
                end else if (ap_ready) begin
                    if (ap_done) frame_done = 1'b1;
                    else         state_d    = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (wd_expire)    state_d    = ST_RECOVER;
                else if (ap_done) frame_done = 1'b1;
            end
            ST_RECOVER: begin
                if (ap_idle) state_d = init_done ? ST_ARM : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // init_done is only honoured once the in-flight frame has finished.
        if (frame_done) begin
            frame_cnt_d = frame_cnt_q + FCNT_W'(1);
            state_d     = init_done ? ST_ARM : ST_IDLE;
        end

        // A timeout on the same cycle as err_clr keeps the flag set.
        if (wd_expire)    err_timeout_d = 1'b1;
        else if (err_clr) err_timeout_d = 1'b0;

        ap_start_d   = (state_d == ST_RUN);
        capture_en_d = is_active(state_d);
    end

    always_ff @(posedge clk) begin
        if (RESET) begin
            state_q       <= ST_IDLE;
            sel_v_q       <= SEL_IMPULSE;
            pending_q     <= SEL_IMPULSE;
            frame_cnt_q   <= '0;
            sel_err_q     <= 1'b0;
            err_timeout_q <= 1'b0;
            ap_start_q    <= 1'b0;
            capture_en_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            sel_v_q       <= sel_v_d;
            pending_q     <= pending_d;
            frame_cnt_q   <= frame_cnt_d;
            sel_err_q     <= sel_err_d;
            err_timeout_q <= err_timeout_d;
            ap_start_q    <= ap_start_d;
            capture_en_q  <= capture_en_d;
        end
    end

    assign ap_start    = ap_start_q;
    assign sel_V       = sel_v_q;
    assign capture_en  = capture_en_q;
    assign frame_cnt   = frame_cnt_q;
    assign sel_err     = sel_err_q;
    assign err_timeout = err_timeout_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_filter_ctrl.sv
// Directed bench for filter_ctrl. dut_a uses the default watchdog and a
// 16-bit frame counter; dut_b uses a 50-cycle watchdog and a 4-bit counter.
// Both see the same stimulus.
module tb_filter_ctrl;

    localparam logic [31:0] S_IDLE = 32'd0;
    localparam logic [31:0] S_ARM  = 32'd1;
    localparam logic [31:0] S_RUN  = 32'd2;
    localparam logic [31:0] S_WAIT = 32'd3;
    localparam logic [31:0] S_REC  = 32'd4;

    logic        clk = 1'b0;
    logic        RESET;
    logic        init_done, frame_start, sel_req_valid;
    logic [2:0]  sel_req;
    logic        ap_ready, ap_done, ap_idle, err_clr;

    logic        ap_start_a, capture_en_a, sel_err_a, err_timeout_a;
    logic [2:0]  sel_v_a, state_a;
    logic [15:0] frame_cnt_a;

    logic        ap_start_b, capture_en_b, sel_err_b, err_timeout_b;
    logic [2:0]  sel_v_b, state_b;
    logic [3:0]  frame_cnt_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    filter_ctrl dut_a (
        .clk(clk), .RESET(RESET), .init_done(init_done), .frame_start(frame_start),
        .sel_req(sel_req), .sel_req_valid(sel_req_valid), .ap_ready(ap_ready),
        .ap_done(ap_done), .ap_idle(ap_idle), .err_clr(err_clr),
        .ap_start(ap_start_a), .sel_V(sel_v_a), .capture_en(capture_en_a),
        .frame_cnt(frame_cnt_a), .sel_err(sel_err_a), .err_timeout(err_timeout_a),
        .state_o(state_a)
    );

    filter_ctrl #(.TIMEOUT_CYCLES(50), .FCNT_W(4)) dut_b (
        .clk(clk), .RESET(RESET), .init_done(init_done), .frame_start(frame_start),
        .sel_req(sel_req), .sel_req_valid(sel_req_valid), .ap_ready(ap_ready),
        .ap_done(ap_done), .ap_idle(ap_idle), .err_clr(err_clr),
        .ap_start(ap_start_b), .sel_V(sel_v_b), .capture_en(capture_en_b),
        .frame_cnt(frame_cnt_b), .sel_err(sel_err_b), .err_timeout(err_timeout_b),
        .state_o(state_b)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        step();
        RESET = 1'b0;
    endtask

    initial begin
        int hi;
        int cap_low;

        RESET = 1'b1; init_done = 1'b0; frame_start = 1'b0;
        sel_req = 3'd0; sel_req_valid = 1'b0;
        ap_ready = 1'b0; ap_done = 1'b0; ap_idle = 1'b0; err_clr = 1'b0;

        // Reset values
        step();
        step();
        check("rst_state",    32'(state_a), S_IDLE);
        check("rst_ap_start", 32'(ap_start_a), 32'd0);
        check("rst_capture",  32'(capture_en_a), 32'd0);
        check("rst_sel_v",    32'(sel_v_a), 32'd0);
        check("rst_fcnt",     32'(frame_cnt_a), 32'd0);
        check("rst_sel_err",  32'(sel_err_a), 32'd0);
        check("rst_err_to",   32'(err_timeout_a), 32'd0);
        RESET = 1'b0;

        // Basic frame: ap_ready after 3 cycles, ap_done ~100 cycles later
        init_done = 1'b1;
        step();
        check("arm_state", 32'(state_a), S_ARM);
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        check("run_state",   32'(state_a), S_RUN);
        check("run_capture", 32'(capture_en_a), 32'd1);
        hi = int'(ap_start_a);
        for (int i = 0; i < 3; i++) begin
            step();
            hi += int'(ap_start_a);
        end
        ap_ready = 1'b1;
        step();
        ap_ready = 1'b0;
        check("wait_state", 32'(state_a), S_WAIT);
        hi += int'(ap_start_a);
        cap_low = 0;
        for (int i = 0; i < 99; i++) begin
            step();
            hi += int'(ap_start_a);
            if (!capture_en_a) cap_low++;
        end
        ap_done = 1'b1;
        step();
        ap_done = 1'b0;
        check("ap_start_cycles", 32'(hi), 32'd4);
        check("capture_gaps",    32'(cap_low), 32'd0);
        check("f1_fcnt",         32'(frame_cnt_a), 32'd1);
        check("f1_state",        32'(state_a), S_ARM);
        check("f1_capture_off",  32'(capture_en_a), 32'd0);
        check("f1_sel_v",        32'(sel_v_a), 32'd0);

        // Mid-frame select changes; reserved code rejected
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        sel_req = 3'd2; sel_req_valid = 1'b1;
        step();
        sel_req_valid = 1'b0;
        check("mid_sel_v_hold", 32'(sel_v_a), 32'd0);
        sel_req = 3'd5; sel_req_valid = 1'b1;
        step();
        sel_req_valid = 1'b0;
        check("sel_err_pulse", 32'(sel_err_a), 32'd1);
        step();
        check("sel_err_clear", 32'(sel_err_a), 32'd0);
        ap_ready = 1'b1; ap_done = 1'b1;
        step();
        ap_ready = 1'b0; ap_done = 1'b0;
        check("rdy_done_state", 32'(state_a), S_ARM);
        check("rdy_done_fcnt",  32'(frame_cnt_a), 32'd2);
        check("f2_sel_v_hold",  32'(sel_v_a), 32'd0);
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        check("f3_sel_v", 32'(sel_v_a), 32'd2);
        ap_ready = 1'b1;
        step();
        ap_ready = 1'b0;
        ap_done = 1'b1;
        step();
        ap_done = 1'b0;
        check("f3_fcnt", 32'(frame_cnt_a), 32'd3);

        // Select request coincident with the launch edge
        sel_req = 3'd1; sel_req_valid = 1'b1; frame_start = 1'b1;
        step();
        sel_req_valid = 1'b0; frame_start = 1'b0;
        check("coinc_sel_v_old", 32'(sel_v_a), 32'd2);
        ap_ready = 1'b1; ap_done = 1'b1;
        step();
        ap_ready = 1'b0; ap_done = 1'b0;
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        check("coinc_sel_v_new", 32'(sel_v_a), 32'd1);
        ap_ready = 1'b1;
        step();
        ap_ready = 1'b0;

        // init_done dropped in WAIT_DONE: frame still completes
        init_done = 1'b0;
        step();
        check("drop_wait_state", 32'(state_a), S_WAIT);
        ap_done = 1'b1;
        step();
        ap_done = 1'b0;
        check("drop_done_state", 32'(state_a), S_IDLE);
        check("drop_done_fcnt",  32'(frame_cnt_a), 32'd5);

        // RESET asserted in RUN
        init_done = 1'b1;
        step();
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        check("pre_rst_ap_start", 32'(ap_start_a), 32'd1);
        RESET = 1'b1;
        step();
        RESET = 1'b0;
        check("mid_rst_ap_start", 32'(ap_start_a), 32'd0);
        check("mid_rst_capture",  32'(capture_en_a), 32'd0);
        check("mid_rst_state",    32'(state_a), S_IDLE);
        check("mid_rst_fcnt",     32'(frame_cnt_a), 32'd0);
        check("mid_rst_sel_v",    32'(sel_v_a), 32'd0);

        // Watchdog on dut_b (limit 50)
        step();
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        ap_ready = 1'b1; ap_done = 1'b1;
        step();
        ap_ready = 1'b0; ap_done = 1'b0;
        check("wd_pre_fcnt", 32'(frame_cnt_b), 32'd1);
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        for (int i = 0; i < 49; i++) step();
        check("wd_cycle49_state", 32'(state_b), S_RUN);
        check("wd_cycle49_err",   32'(err_timeout_b), 32'd0);
        step();
        check("wd_recover_state", 32'(state_b), S_REC);
        check("wd_err_set",       32'(err_timeout_b), 32'd1);
        check("wd_fcnt_hold",     32'(frame_cnt_b), 32'd1);
        check("wd_ap_start",      32'(ap_start_b), 32'd0);
        check("wd_capture",       32'(capture_en_b), 32'd0);
        step();
        check("wd_wait_idle", 32'(state_b), S_REC);
        ap_idle = 1'b1;
        step();
        ap_idle = 1'b0;
        check("wd_to_arm",   32'(state_b), S_ARM);
        check("wd_err_held", 32'(err_timeout_b), 32'd1);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check("wd_err_cleared", 32'(err_timeout_b), 32'd0);

        // Timeout coincident with err_clr keeps the flag; RECOVER -> IDLE
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        for (int i = 0; i < 49; i++) step();
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check("wd_clr_race_err", 32'(err_timeout_b), 32'd1);
        check("wd_clr_race_st",  32'(state_b), S_REC);
        init_done = 1'b0; ap_idle = 1'b1;
        step();
        ap_idle = 1'b0;
        check("wd_to_idle", 32'(state_b), S_IDLE);

        // 4-bit frame counter wrap on dut_b
        do_reset();
        init_done = 1'b1;
        step();
        for (int f = 0; f < 16; f++) begin
            frame_start = 1'b1;
            step();
            frame_start = 1'b0;
            ap_ready = 1'b1; ap_done = 1'b1;
            step();
            ap_ready = 1'b0; ap_done = 1'b0;
            if (f == 14) check("wrap_fcnt_15", 32'(frame_cnt_b), 32'd15);
        end
        check("wrap_fcnt_0",  32'(frame_cnt_b), 32'd0);
        check("wide_fcnt_16", 32'(frame_cnt_a), 32'd16);
        check("wrap_state",   32'(state_b), S_ARM);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
